prf_free_list: RTL and testbench

- Banked free list of physical registers: the return/supply end of PR allocation.
- Rename pops free PRs, one per bank per cycle. Commit/flush pushes released PRs back.
- Banking matches the PRF banks (PR index low bits select the bank), so rename can pick PRs that spread writeback load across banks.
- Sits between the rename stage (alloc side) and the ROB commit/rollback logic (free side).

---
 rtl/core_types_pkg.sv | 32 +++
 rtl/prf_free_list_if.sv | 33 +++
 rtl/prf_free_list_bank.sv | 65 ++++++
 rtl/prf_free_list.sv | 45 ++++
 tb/tb_prf_free_list.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// Shared core sizing for the physical register file and its free list.
// Also holds the reset-layout helpers used by each free-list bank.
package core_types_pkg;

  localparam int unsigned PR_COUNT           = 128;
  localparam int unsigned LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int unsigned AR_COUNT           = 32;
  localparam int unsigned BANK_DEPTH         = PR_COUNT / PRF_BANK_COUNT;
  localparam int unsigned LOG_BANK_DEPTH     = $clog2(BANK_DEPTH);

  typedef logic [LOG_PR_COUNT-1:0]   pr_t;
  typedef logic [LOG_BANK_DEPTH:0]   bank_count_t;
  typedef logic [LOG_BANK_DEPTH-1:0] bank_ptr_t;

  // Lowest PR at or above AR_COUNT that belongs to the given bank.
  function automatic int unsigned first_free_pr(input int unsigned bank);
    return AR_COUNT +
           ((bank + PRF_BANK_COUNT - (AR_COUNT % PRF_BANK_COUNT)) % PRF_BANK_COUNT);
  endfunction

  // Number of unmapped PRs that live in the given bank at reset.
  function automatic int unsigned init_count(input int unsigned bank);
    int unsigned first;
    first = first_free_pr(bank);
    if (first >= PR_COUNT)
      return 0;
    return (PR_COUNT - first + PRF_BANK_COUNT - 1) / PRF_BANK_COUNT;
  endfunction

endpackage

// File: rtl/prf_free_list_if.sv
// Alloc/free bundle between rename, ROB commit/rollback and the PR free list.
interface prf_free_list_if;
  import core_types_pkg::*;

  logic [PRF_BANK_COUNT-1:0]        alloc_req_by_bank;
  logic [PRF_BANK_COUNT-1:0]        alloc_ready_by_bank;
  pr_t [PRF_BANK_COUNT-1:0]         alloc_pr_by_bank;
  logic [PRF_BANK_COUNT-1:0]        free_valid_by_bank;
  pr_t [PRF_BANK_COUNT-1:0]         free_pr_by_bank;
  bank_count_t [PRF_BANK_COUNT-1:0] free_count_by_bank;
  logic                             error_overflow;

  modport master (
    output alloc_req_by_bank,
    output free_valid_by_bank,
    output free_pr_by_bank,
    input  alloc_ready_by_bank,
    input  alloc_pr_by_bank,
    input  free_count_by_bank,
    input  error_overflow
  );

  modport slave (
    input  alloc_req_by_bank,
    input  free_valid_by_bank,
    input  free_pr_by_bank,
    output alloc_ready_by_bank,
    output alloc_pr_by_bank,
    output free_count_by_bank,
    output error_overflow
  );

endinterface

// File: rtl/prf_free_list_bank.sv
// One bank of the PR free list: circular FIFO with first-word fall-through,
// reset-loaded with the unmapped PRs whose low index bits equal BANK_IDX.
module prf_free_list_bank
  import core_types_pkg::*;
#(
  parameter int unsigned BANK_IDX = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        alloc_req,
  output logic        alloc_ready,
  output pr_t         alloc_pr,
  input  logic        free_valid,
  input  pr_t         free_pr,
  output bank_count_t count,
  output logic        error
);

  localparam int unsigned INIT_COUNT = init_count(BANK_IDX);
  localparam int unsigned INIT_FIRST = first_free_pr(BANK_IDX);

  pr_t         mem [BANK_DEPTH];
  bank_ptr_t   head;
  bank_ptr_t   tail;
  bank_count_t count_q;

  logic pop;
  logic push;
  logic full;
  logic mismatch;

  // A full bank still accepts a push when the same cycle pops, so the
  // slot being vacated at head absorbs the write at tail.
  always_comb begin
    alloc_ready = (count_q != '0);
    alloc_pr    = mem[head];
    full        = (count_q == bank_count_t'(BANK_DEPTH));
    pop         = alloc_req & alloc_ready;
    push        = free_valid & (~full | pop);
    mismatch    = (free_pr[LOG_PRF_BANK_COUNT-1:0] != LOG_PRF_BANK_COUNT'(BANK_IDX));
    error       = free_valid & ((full & ~pop) | mismatch);
  end

  assign count = count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head    <= '0;
      tail    <= bank_ptr_t'(INIT_COUNT);
      count_q <= bank_count_t'(INIT_COUNT);
      for (int unsigned i = 0; i < BANK_DEPTH; i++) begin
        mem[i] <= (i < INIT_COUNT) ? pr_t'(INIT_FIRST + i * PRF_BANK_COUNT) : '0;
      end
    end else begin
      if (pop)
        head <= head + bank_ptr_t'(1);
      if (push) begin
        mem[tail] <= free_pr;
        tail      <= tail + bank_ptr_t'(1);
      end
      count_q <= count_q + bank_count_t'(push) - bank_count_t'(pop);
    end
  end

endmodule

// File: rtl/prf_free_list.sv
// Banked physical-register free list: one independent FIFO per PRF bank,
// plus a sticky overflow/bank-mismatch flag shared across banks.
module prf_free_list
  import core_types_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  prf_free_list_if.slave bus
);

  logic [PRF_BANK_COUNT-1:0]        bank_ready;
  pr_t [PRF_BANK_COUNT-1:0]         bank_pr;
  bank_count_t [PRF_BANK_COUNT-1:0] bank_count;
  logic [PRF_BANK_COUNT-1:0]        bank_error;
  logic                             error_q;

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    prf_free_list_bank #(
      .BANK_IDX(b)
    ) u_bank (
      .CLK         (CLK),
      .RST         (RST),
      .alloc_req   (bus.alloc_req_by_bank[b]),
      .alloc_ready (bank_ready[b]),
      .alloc_pr    (bank_pr[b]),
      .free_valid  (bus.free_valid_by_bank[b]),
      .free_pr     (bus.free_pr_by_bank[b]),
      .count       (bank_count[b]),
      .error       (bank_error[b])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST)
      error_q <= 1'b0;
    else if (|bank_error)
      error_q <= 1'b1;
  end

  assign bus.alloc_ready_by_bank = bank_ready;
  assign bus.alloc_pr_by_bank    = bank_pr;
  assign bus.free_count_by_bank  = bank_count;
  assign bus.error_overflow      = error_q;

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list: a short vector table plus hand-written
// sequences for drain, empty push/pop, wrap-around, full bank and reset.
module tb_prf_free_list;
  import core_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prf_free_list_if bus ();

  prf_free_list dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  areq;
    logic [3:0]  fv;
    pr_t [3:0]   fpr;
    logic [3:0]  ready;
    int          pr  [4];
    int          cnt [4];
    logic        err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one cycle of requests, wait past the edge, return to idle.
  task automatic cycle(input logic r, input logic [3:0] areq,
                       input logic [3:0] fv, input pr_t [3:0] fpr);
    rst                    = r;
    bus.alloc_req_by_bank  = areq;
    bus.free_valid_by_bank = fv;
    bus.free_pr_by_bank    = fpr;
    @(posedge clk);
    #1;
    rst                    = 1'b0;
    bus.alloc_req_by_bank  = '0;
    bus.free_valid_by_bank = '0;
    bus.free_pr_by_bank    = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ready"}, int'(bus.alloc_ready_by_bank), 15);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("%s.pr%0d", tag, b), int'(bus.alloc_pr_by_bank[b]), 32 + b);
      check($sformatf("%s.cnt%0d", tag, b), int'(bus.free_count_by_bank[b]), 24);
    end
    check({tag, ".err"}, int'(bus.error_overflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp;

    vecs[0] = '{areq: 4'b1111, fv: 4'b0000, fpr: '0,
                ready: 4'b1111, pr: '{36, 37, 38, 39}, cnt: '{23, 23, 23, 23}, err: 1'b0};
    vecs[1] = '{areq: 4'b0001, fv: 4'b0100, fpr: {7'd0, 7'd2, 7'd0, 7'd0},
                ready: 4'b1111, pr: '{40, 37, 38, 39}, cnt: '{22, 23, 24, 23}, err: 1'b0};
    vecs[2] = '{areq: 4'b1010, fv: 4'b1000, fpr: {7'd3, 7'd0, 7'd0, 7'd0},
                ready: 4'b1111, pr: '{40, 41, 38, 43}, cnt: '{22, 22, 24, 23}, err: 1'b0};
    vecs[3] = '{areq: 4'b0000, fv: 4'b0000, fpr: '0,
                ready: 4'b1111, pr: '{40, 41, 38, 43}, cnt: '{22, 22, 24, 23}, err: 1'b0};

    bus.alloc_req_by_bank  = '0;
    bus.free_valid_by_bank = '0;
    bus.free_pr_by_bank    = '0;
    @(posedge clk);
    #1;

    // Reset state.
    cycle(1'b1, '0, '0, '0);
    check_reset_state("reset");

    // Table-driven mixed traffic from reset.
    for (int v = 0; v < 4; v++) begin
      cycle(1'b0, vecs[v].areq, vecs[v].fv, vecs[v].fpr);
      check($sformatf("vec%0d.ready", v), int'(bus.alloc_ready_by_bank), int'(vecs[v].ready));
      for (int b = 0; b < 4; b++) begin
        if (vecs[v].ready[b])
          check($sformatf("vec%0d.pr%0d", v, b), int'(bus.alloc_pr_by_bank[b]), vecs[v].pr[b]);
        check($sformatf("vec%0d.cnt%0d", v, b), int'(bus.free_count_by_bank[b]), vecs[v].cnt[b]);
      end
      check($sformatf("vec%0d.err", v), int'(bus.error_overflow), int'(vecs[v].err));
    end

    // Drain bank 0 completely, then pop an empty bank.
    cycle(1'b1, '0, '0, '0);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("drain.pr0[%0d]", i), int'(bus.alloc_pr_by_bank[0]), 32 + 4 * i);
      cycle(1'b0, 4'b0001, '0, '0);
    end
    check("drain.ready0", int'(bus.alloc_ready_by_bank[0]), 0);
    check("drain.cnt0", int'(bus.free_count_by_bank[0]), 0);
    cycle(1'b0, 4'b0001, '0, '0);
    check("empty_pop.ready0", int'(bus.alloc_ready_by_bank[0]), 0);
    check("empty_pop.cnt0", int'(bus.free_count_by_bank[0]), 0);
    check("empty_pop.err", int'(bus.error_overflow), 0);
    check("empty_pop.cnt1", int'(bus.free_count_by_bank[1]), 24);

    // Empty bank: push and pop together, pop must not happen.
    cycle(1'b0, 4'b0001, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd40});
    check("empty_pp.ready0", int'(bus.alloc_ready_by_bank[0]), 1);
    check("empty_pp.pr0", int'(bus.alloc_pr_by_bank[0]), 40);
    check("empty_pp.cnt0", int'(bus.free_count_by_bank[0]), 1);

    // Bank 1: recycle each popped PR so tail wraps, then top up to full.
    for (int i = 0; i < 24; i++) begin
      check($sformatf("wrap.pr1[%0d]", i), int'(bus.alloc_pr_by_bank[1]), 33 + 4 * i);
      cycle(1'b0, 4'b0010, 4'b0010, {7'd0, 7'd0, 7'(33 + 4 * i), 7'd0});
    end
    check("wrap.cnt1_mid", int'(bus.free_count_by_bank[1]), 24);
    for (int j = 0; j < 8; j++)
      cycle(1'b0, '0, 4'b0010, {7'd0, 7'd0, 7'(1 + 4 * j), 7'd0});
    check("wrap.cnt1_full", int'(bus.free_count_by_bank[1]), 32);
    check("wrap.pr1_head", int'(bus.alloc_pr_by_bank[1]), 33);
    check("wrap.err", int'(bus.error_overflow), 0);

    // Full bank: pop+push is legal, a lone push is dropped and flagged.
    cycle(1'b0, 4'b0010, 4'b0010, {7'd0, 7'd0, 7'd33, 7'd0});
    check("full_pp.cnt1", int'(bus.free_count_by_bank[1]), 32);
    check("full_pp.err", int'(bus.error_overflow), 0);
    check("full_pp.pr1", int'(bus.alloc_pr_by_bank[1]), 37);
    cycle(1'b0, '0, 4'b0010, {7'd0, 7'd0, 7'd41, 7'd0});
    check("full_push.cnt1", int'(bus.free_count_by_bank[1]), 32);
    check("full_push.err", int'(bus.error_overflow), 1);
    cycle(1'b0, '0, '0, '0);
    check("sticky.err", int'(bus.error_overflow), 1);

    // Drain bank 1: FIFO order across the wrap, dropped PR 41 absent.
    for (int j = 0; j < 32; j++) begin
      if (j < 23)      exp = 37 + 4 * j;
      else if (j < 31) exp = 1 + 4 * (j - 23);
      else             exp = 33;
      check($sformatf("order.pr1[%0d]", j), int'(bus.alloc_pr_by_bank[1]), exp);
      cycle(1'b0, 4'b0010, '0, '0);
    end
    check("order.ready1", int'(bus.alloc_ready_by_bank[1]), 0);
    check("order.cnt1", int'(bus.free_count_by_bank[1]), 0);
    check("order.err_sticky", int'(bus.error_overflow), 1);

    // Bank-index mismatch still pushes but flags an error.
    cycle(1'b1, '0, '0, '0);
    check("mm.err_before", int'(bus.error_overflow), 0);
    cycle(1'b0, '0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd6});
    check("mm.err", int'(bus.error_overflow), 1);
    check("mm.cnt0", int'(bus.free_count_by_bank[0]), 25);

    // Reset in the middle of four-bank traffic, with traffic on the reset edge.
    cycle(1'b0, 4'b1111, 4'b1111, {7'd35, 7'd34, 7'd33, 7'd32});
    cycle(1'b0, 4'b0101, 4'b1010, {7'd39, 7'd38, 7'd37, 7'd36});
    cycle(1'b1, 4'b1111, 4'b1111, {7'd3, 7'd2, 7'd1, 7'd0});
    check_reset_state("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
